// File: rtl/b12_key_pkg.sv
// Shared types and constants for the b12 key front end.
// Latency: n/a (package only).
// Backpressure: n/a.
package b12_key_pkg;

   // Key FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EMIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CHORD = 2'd3
   } key_st_e;

   // Button bit positions inside the 4-bit colour vector
   localparam int unsigned BTN_RED    = 0;
   localparam int unsigned BTN_GREEN  = 1;
   localparam int unsigned BTN_YELLOW = 2;
   localparam int unsigned BTN_BLUE   = 3;
   localparam int unsigned KEY_W      = BTN_BLUE + 1;

   localparam int unsigned DEB_CYCLES_DEF = 8;

   // True when exactly one bit of the key vector is set
   function automatic logic is_onehot(input logic [KEY_W-1:0] v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/b12_key_frontend_if.sv
// Button/strobe bundle between the panel side and the key front end.
// Latency: n/a (wires only).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
//   btn[3:0]  raw colour buttons (async), btn_start raw start button (async)
//   k[3:0]    one-hot key strobe, start start strobe, busy key FSM not idle
interface b12_key_frontend_if;
   import b12_key_pkg::*;

   logic [KEY_W-1:0] btn;
   logic             btn_start;
   logic [KEY_W-1:0] k;
   logic             start;
   logic             busy;

   // master: panel / testbench side, slave: the front end
   modport master (output btn, btn_start, input  k, start, busy);
   modport slave  (input  btn, btn_start, output k, start, busy);

endinterface

// File: rtl/b12_debounce.sv
// Two-flop synchronizer followed by a per-vector stability filter.
// Latency: raw change to db_o is DEB_CYCLES+3 edges.
// Backpressure: none; always accepts input.
//   clock, reset (sync, active-high), raw_i[W-1:0] async in, db_o[W-1:0] clean out
module b12_debounce
   import b12_key_pkg::*;
#(
   parameter int unsigned W          = 1,
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int unsigned CNT_W      = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] db_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [W-1:0]     s1_q;
   logic [W-1:0]     s2_q;
   logic [W-1:0]     cand_q;
   logic [W-1:0]     db_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         cand_q <= '0;
         db_q   <= '0;
         cnt_q  <= '0;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
         // The commit is taken whenever the candidate has been seen for
         // DEB_CYCLES samples, even on the edge where s2 moves away again.
         // That way a pulse of exactly DEB_CYCLES cycles is accepted while
         // the commit edge stays DEB_CYCLES after the candidate load.
         if (cnt_q == CNT_MAX) begin
            db_q <= cand_q;
         end
         if (s2_q != cand_q) begin
            cand_q <= s2_q;
            cnt_q  <= '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign db_o = db_q;

endmodule

// File: rtl/b12_key_frontend.sv
// Debounced colour/start buttons to single-cycle one-hot k and start strobes.
// Latency: raw press to strobe is DEB_CYCLES+4 edges.
// Backpressure: none; held keys never repeat, chords are dropped.
//   clock, reset (sync, active-high), bus (slave): btn/btn_start in, k/start/busy out
module b12_key_frontend
   import b12_key_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int unsigned CNT_W      = 6
) (
   input  logic                clock,
   input  logic                reset,
   b12_key_frontend_if.slave   bus
);

   logic [KEY_W-1:0] db_key;
   logic             db_start;
   logic             db_start_q;
   key_st_e          st_q;
   logic [KEY_W-1:0] k_q;
   logic             start_q;
   logic             busy_q;

   b12_debounce #(.W(KEY_W), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_key (
      .clock (clock),
      .reset (reset),
      .raw_i (bus.btn),
      .db_o  (db_key)
   );

   b12_debounce #(.W(1), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_start (
      .clock (clock),
      .reset (reset),
      .raw_i (bus.btn_start),
      .db_o  (db_start)
   );

   // Key FSM: one strobe per press, then wait for all keys released
   always_ff @(posedge clock) begin
      if (reset) begin
         st_q   <= ST_IDLE;
         k_q    <= '0;
         busy_q <= 1'b0;
      end else begin
         case (st_q)
            ST_IDLE: begin
               if (db_key != '0) begin
                  busy_q <= 1'b1;
                  if (is_onehot(db_key)) begin
                     st_q <= ST_EMIT;
                     k_q  <= db_key;
                  end else begin
                     st_q <= ST_CHORD;
                  end
               end
            end
            ST_EMIT: begin
               k_q  <= '0;
               st_q <= ST_HOLD;
            end
            ST_HOLD, ST_CHORD: begin
               if (db_key == '0) begin
                  st_q   <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               st_q   <= ST_IDLE;
               k_q    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Start strobe: rising edge of the debounced start, independent of keys
   always_ff @(posedge clock) begin
      if (reset) begin
         db_start_q <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         db_start_q <= db_start;
         start_q    <= db_start & ~db_start_q;
      end
   end

   assign bus.k     = k_q;
   assign bus.start = start_q;
   assign bus.busy  = busy_q;

endmodule
